// File: rtl/stream_vadd_multi_pkg.sv
// Shared types and token helper for the multi-lane stream combiner.
// Token layout: payload in the low bits, end-of-transfer flag just above the payload.
package stream_vadd_pkg;

   localparam int MAX_DW = 128;

   typedef enum logic [1:0] {
      ADD  = 2'd0,
      SUB  = 2'd1,
      MAX  = 2'd2,
      RSVD = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_EMIT_EOT,
      S_DONE
   } state_e;

   // Caller zero-extends data; eot lands at bit position dw.
   function automatic logic [MAX_DW:0] mk_token(input logic eot,
                                                input logic [MAX_DW-1:0] data,
                                                input logic [7:0] dw);
      logic [MAX_DW:0] t;
      t     = {1'b0, data};
      t[dw] = eot;
      return t;
   endfunction

endpackage

// File: rtl/stream_vadd_multi_if.sv
// Stream bundle: NUM_IN FIFO-read lanes in, one FIFO-write stream out.
interface stream_vadd_multi_if #(
   parameter int NUM_IN     = 2,
   parameter int DATA_WIDTH = 32
);
   localparam int TOKEN_W = DATA_WIDTH + 1;

   logic [NUM_IN*TOKEN_W-1:0] in_dout;
   logic [NUM_IN-1:0]         in_empty_n;
   logic [NUM_IN-1:0]         in_read;
   logic [TOKEN_W-1:0]        out_din;
   logic                      out_full_n;
   logic                      out_write;

   modport slave (
      input  in_dout, in_empty_n, out_full_n,
      output in_read, out_din, out_write
   );

   modport master (
      output in_dout, in_empty_n, out_full_n,
      input  in_read, out_din, out_write
   );
endinterface

// File: rtl/stream_vadd_multi_out_reg.sv
// One-entry output buffer; a load may coincide with the sink taking the held token.
module stream_out_reg #(
   parameter int TOKEN_W = 33
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TOKEN_W-1:0] data,
   input  logic               full_n,
   output logic               slot_free,
   output logic [TOKEN_W-1:0] din,
   output logic               write,
   output logic               valid
);

   assign write     = valid & full_n;
   assign slot_free = ~valid | full_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         din   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         din   <= data;
      end else if (write) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_vadd_multi.sv
// Lane-wise reduction of NUM_IN token streams into one stream under ap_ctrl_hs.
// state      | meaning
// S_IDLE     | waiting for ap_start; ap_idle high
// S_RUN      | combining one token from every lane per fire
// S_DRAIN    | reading each lane up to and including its eot
// S_EMIT_EOT | loading the close token into the output register
// S_DONE     | waiting for the close token to leave, then done/ready
module stream_vadd_multi
   import stream_vadd_pkg::*;
#(
   parameter int NUM_IN     = 2,
   parameter int DATA_WIDTH = 32
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic        ap_start,
   output logic        ap_done,
   output logic        ap_idle,
   output logic        ap_ready,
   input  logic [63:0] n,
   input  logic [1:0]  op,
   output logic        err,
   stream_vadd_multi_if.slave bus
);

   localparam int         TOKEN_W = DATA_WIDTH + 1;
   localparam logic [7:0] DW8     = 8'(DATA_WIDTH);

   state_e                 state;
   op_e                    op_r;
   logic [63:0]            n_r;
   logic [63:0]            count;
   logic [NUM_IN-1:0]      seen;
   logic [NUM_IN-1:0]      seen_nxt;
   logic [NUM_IN-1:0]      eot_vec;
   logic [DATA_WIDTH-1:0]  lane_data [NUM_IN];
   logic [DATA_WIDTH-1:0]  result;
   logic [MAX_DW-1:0]      res_ext;
   logic [MAX_DW:0]        tok_full;
   logic [TOKEN_W-1:0]     load_data;
   logic                   slot_free;
   logic                   out_valid;
   logic                   fire;
   logic                   load;
   logic                   drain_err;
   logic                   unused_tok_hi;

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         lane_data[i] = bus.in_dout[i*TOKEN_W +: DATA_WIDTH];
         eot_vec[i]   = bus.in_dout[i*TOKEN_W + DATA_WIDTH];
      end
   end

   // Sub chains lane0 - lane1 - ..., which equals lane0 minus the sum of the rest mod 2^W.
   always_comb begin
      logic [DATA_WIDTH-1:0] acc;
      acc = lane_data[0];
      for (int i = 1; i < NUM_IN; i++) begin
         case (op_r)
            SUB:     acc = acc - lane_data[i];
            MAX:     if (lane_data[i] > acc) acc = lane_data[i];
            default: acc = acc + lane_data[i];
         endcase
      end
      result = acc;
   end

   assign fire = (state == S_RUN) && (&bus.in_empty_n) && slot_free;

   always_comb begin
      case (state)
         S_RUN:   bus.in_read = {NUM_IN{fire}};
         S_DRAIN: bus.in_read = bus.in_empty_n & ~seen;
         default: bus.in_read = '0;
      endcase
   end

   assign seen_nxt  = seen | (bus.in_read & eot_vec);
   assign drain_err = |(bus.in_read & ~eot_vec);

   always_comb begin
      res_ext                   = '0;
      res_ext[DATA_WIDTH-1:0]   = result;
      if (state == S_EMIT_EOT)
         tok_full = mk_token(1'b1, '0, DW8);
      else
         tok_full = mk_token(1'b0, res_ext, DW8);
      load_data = tok_full[TOKEN_W-1:0];
   end

   assign unused_tok_hi = ^tok_full[MAX_DW:TOKEN_W];

   assign load = (fire && !(|eot_vec)) || ((state == S_EMIT_EOT) && slot_free);

   stream_out_reg #(.TOKEN_W(TOKEN_W)) u_oreg (
      .clk       (ap_clk),
      .rst       (ap_rst),
      .load      (load),
      .data      (load_data),
      .full_n    (bus.out_full_n),
      .slot_free (slot_free),
      .din       (bus.out_din),
      .write     (bus.out_write),
      .valid     (out_valid)
   );

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state    <= S_IDLE;
         ap_idle  <= 1'b1;
         ap_done  <= 1'b0;
         ap_ready <= 1'b0;
         err      <= 1'b0;
         n_r      <= '0;
         op_r     <= ADD;
         count    <= '0;
         seen     <= '0;
      end else begin
         ap_done  <= 1'b0;
         ap_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               // ap_start is still held in the ap_ready cycle; ignore it there.
               if (ap_start && !ap_done) begin
                  n_r     <= n;
                  op_r    <= op_e'(op);
                  count   <= '0;
                  seen    <= '0;
                  err     <= 1'b0;
                  ap_idle <= 1'b0;
                  state   <= (n == 64'd0) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               if (fire) begin
                  if (|eot_vec) begin
                     err   <= 1'b1;
                     seen  <= eot_vec;
                     state <= S_DRAIN;
                  end else begin
                     count <= count + 64'd1;
                     if (count + 64'd1 == n_r) state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               seen <= seen_nxt;
               if (drain_err) err <= 1'b1;
               if (&seen_nxt) state <= S_EMIT_EOT;
            end
            S_EMIT_EOT: begin
               if (slot_free) state <= S_DONE;
            end
            S_DONE: begin
               if (!out_valid) begin
                  ap_done  <= 1'b1;
                  ap_ready <= 1'b1;
                  ap_idle  <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_vadd_multi.sv
// Directed bench for stream_vadd_multi with three lanes and 32-bit payloads.
module tb_stream_vadd_multi;

   localparam int NL = 3;
   localparam int DW = 32;
   localparam int TW = DW + 1;
   localparam logic [TW-1:0] EOT = {1'b1, 32'h0};

   logic        ap_clk;
   logic        ap_rst;
   logic        ap_start;
   logic        ap_done;
   logic        ap_idle;
   logic        ap_ready;
   logic [63:0] ap_n;
   logic [1:0]  ap_op;
   logic        err;

   stream_vadd_multi_if #(.NUM_IN(NL), .DATA_WIDTH(DW)) bus ();

   stream_vadd_multi #(.NUM_IN(NL), .DATA_WIDTH(DW)) dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .ap_start (ap_start),
      .ap_done  (ap_done),
      .ap_idle  (ap_idle),
      .ap_ready (ap_ready),
      .n        (ap_n),
      .op       (ap_op),
      .err      (err),
      .bus      (bus)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic [TW-1:0] lane_mem [NL][8];
   int            lane_len [NL];
   int            lane_ptr [NL];
   logic          tb_clear;
   logic          full_mode;
   logic          full_tog;
   logic [TW-1:0] got_mem [64];
   int            got_n;
   int            done_cnt;
   int            ready_bad;
   int            bad_read;
   int            stall_bad;
   int            stall_seen;
   logic [TW-1:0] held;
   logic          held_ok;
   logic [TW-1:0] exp_q [$];
   int            n_cmp;
   int            n_bad;

   always_comb begin
      for (int i = 0; i < NL; i++) begin
         bus.in_empty_n[i]       = lane_ptr[i] < lane_len[i];
         bus.in_dout[i*TW +: TW] = (lane_ptr[i] < lane_len[i]) ? lane_mem[i][lane_ptr[i]] : '0;
      end
   end

   always @(posedge ap_clk) begin
      for (int i = 0; i < NL; i++) begin
         if (tb_clear) lane_ptr[i] <= 0;
         else if (bus.in_read[i]) lane_ptr[i] <= lane_ptr[i] + 1;
      end
      full_tog <= full_mode ? ~full_tog : 1'b1;
   end

   assign bus.out_full_n = full_tog;

   initial begin
      got_n = 0; done_cnt = 0; ready_bad = 0; bad_read = 0;
      stall_bad = 0; stall_seen = 0; held = '0; held_ok = 1'b0; full_tog = 1'b1;
   end

   always @(negedge ap_clk) begin
      if (bus.out_write) begin
         got_mem[got_n] <= bus.out_din;
         got_n          <= got_n + 1;
      end
      if (ap_done) done_cnt <= done_cnt + 1;
      if (ap_done != ap_ready) ready_bad <= ready_bad + 1;
      if (|(bus.in_read & ~bus.in_empty_n)) bad_read <= bad_read + 1;
      if (held_ok && bus.out_din != held) stall_bad <= stall_bad + 1;
      if (dut.u_oreg.valid && !bus.out_full_n) begin
         held       <= bus.out_din;
         held_ok    <= 1'b1;
         stall_seen <= stall_seen + 1;
      end else begin
         held_ok <= 1'b0;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [TW-1:0] dtok(input logic [31:0] d);
      return {1'b0, d};
   endfunction

   task automatic clear_lanes();
      for (int i = 0; i < NL; i++) lane_len[i] = 0;
      exp_q.delete();
      tb_clear = 1'b1;
      @(posedge ap_clk);
      #1 tb_clear = 1'b0;
   endtask

   task automatic put(input int l, input logic [TW-1:0] t);
      lane_mem[l][lane_len[l]] = t;
      lane_len[l]++;
   endtask

   task automatic row(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic [TW-1:0] c);
      put(0, a); put(1, b); put(2, c);
   endtask

   task automatic run_xfer(input string tag, input logic [63:0] nn, input logic [1:0] o,
                           output int base_o);
      int cyc;
      int base_d;
      base_o   = got_n;
      base_d   = done_cnt;
      ap_n     = nn;
      ap_op    = o;
      ap_start = 1'b1;
      cyc      = 0;
      do begin
         @(negedge ap_clk);
         cyc++;
      end while (!ap_done && cyc < 300);
      check_val({tag, "_done_seen"}, 64'(ap_done), 64'd1);
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
      repeat (4) @(posedge ap_clk);
      #1;
      check_val({tag, "_done_cnt"}, 64'(done_cnt - base_d), 64'd1);
      check_val({tag, "_idle"}, 64'(ap_idle), 64'd1);
   endtask

   task automatic check_outs(input string tag, input int base);
      check_val({tag, "_out_cnt"}, 64'(got_n - base), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
         if (base + k < got_n)
            check_val($sformatf("%s_out%0d", tag, k), 64'(got_mem[base+k]), 64'(exp_q[k]));
   endtask

   task automatic check_drained(input string tag);
      for (int i = 0; i < NL; i++)
         check_val($sformatf("%s_lane%0d_ptr", tag, i), 64'(lane_ptr[i]), 64'(lane_len[i]));
   endtask

   initial begin
      int base;
      int cyc;
      int ptr_snap [NL];
      int got_snap;
      n_cmp = 0; n_bad = 0;
      ap_rst = 1'b1; ap_start = 1'b0; ap_n = '0; ap_op = '0;
      tb_clear = 1'b1; full_mode = 1'b0;
      for (int i = 0; i < NL; i++) lane_len[i] = 0;
      #1;
      check_val("rst_idle",   64'(ap_idle),        64'd1);
      check_val("rst_done",   64'(ap_done),        64'd0);
      check_val("rst_ready",  64'(ap_ready),       64'd0);
      check_val("rst_write",  64'(bus.out_write),  64'd0);
      check_val("rst_err",    64'(err),            64'd0);
      check_val("rst_read",   64'(bus.in_read),    64'd0);
      check_val("rst_din",    64'(bus.out_din),    64'd0);
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk) ap_rst = 1'b0;

      // add, n=5
      clear_lanes();
      for (int k = 0; k < 5; k++) row(dtok(32'(k)), dtok(32'(k + 1)), dtok(32'd0));
      row(EOT, EOT, EOT);
      exp_q = '{dtok(1), dtok(3), dtok(5), dtok(7), dtok(9), EOT};
      run_xfer("add", 64'd5, 2'd0, base);
      check_outs("add", base);
      check_val("add_err", 64'(err), 64'd0);
      check_drained("add");

      // sub, n=2, with borrow wrap
      clear_lanes();
      row(dtok(10), dtok(3), dtok(2));
      row(dtok(0),  dtok(1), dtok(0));
      row(EOT, EOT, EOT);
      exp_q = '{dtok(5), dtok(32'hFFFF_FFFF), EOT};
      run_xfer("sub", 64'd2, 2'd1, base);
      check_outs("sub", base);
      check_val("sub_err", 64'(err), 64'd0);

      // unsigned max under back-pressure
      clear_lanes();
      full_mode = 1'b1;
      row(dtok(5),   dtok(9),            dtok(1));
      row(dtok(100), dtok(2),            dtok(50));
      row(dtok(7),   dtok(32'hFFFF_FFF0), dtok(8));
      row(EOT, EOT, EOT);
      exp_q = '{dtok(9), dtok(100), dtok(32'hFFFF_FFF0), EOT};
      run_xfer("max", 64'd3, 2'd2, base);
      full_mode = 1'b0;
      check_outs("max", base);
      check_val("max_stall_stable", 64'(stall_bad), 64'd0);
      check_val("max_stall_seen", 64'(stall_seen > 0), 64'd1);

      // early eot on lane1
      clear_lanes();
      put(0, dtok(1));  put(0, dtok(2));  put(0, dtok(3)); put(0, EOT);
      put(1, dtok(10)); put(1, dtok(20)); put(1, EOT);
      put(2, dtok(0));  put(2, dtok(0));  put(2, dtok(0)); put(2, EOT);
      exp_q = '{dtok(11), dtok(22), EOT};
      run_xfer("early", 64'd3, 2'd0, base);
      check_outs("early", base);
      check_val("early_err", 64'(err), 64'd1);
      check_drained("early");

      // n=0: only the close token
      clear_lanes();
      row(EOT, EOT, EOT);
      exp_q = '{EOT};
      run_xfer("zero", 64'd0, 2'd0, base);
      check_outs("zero", base);
      check_val("zero_err", 64'(err), 64'd0);
      check_drained("zero");

      // reset mid-transfer
      clear_lanes();
      for (int k = 1; k <= 5; k++) row(dtok(32'(k)), dtok(0), dtok(0));
      row(EOT, EOT, EOT);
      base = got_n;
      ap_n = 64'd5; ap_op = 2'd0; ap_start = 1'b1;
      cyc = 0;
      do begin
         @(negedge ap_clk);
         cyc++;
      end while (got_n - base < 2 && cyc < 100);
      check_val("rstmid_two_out", 64'(got_n - base >= 2), 64'd1);
      ap_rst = 1'b1;
      ap_start = 1'b0;
      #1;
      check_val("rstmid_write", 64'(bus.out_write), 64'd0);
      check_val("rstmid_read",  64'(bus.in_read),   64'd0);
      check_val("rstmid_idle",  64'(ap_idle),       64'd1);
      check_val("rstmid_din",   64'(bus.out_din),   64'd0);
      check_val("rstmid_err",   64'(err),           64'd0);
      for (int i = 0; i < NL; i++) ptr_snap[i] = lane_ptr[i];
      got_snap = got_n;
      repeat (3) @(posedge ap_clk);
      #1;
      check_val("rstmid_no_out", 64'(got_n), 64'(got_snap));
      for (int i = 0; i < NL; i++)
         check_val($sformatf("rstmid_lane%0d_hold", i), 64'(lane_ptr[i]), 64'(ptr_snap[i]));
      @(negedge ap_clk) ap_rst = 1'b0;

      clear_lanes();
      row(dtok(42), dtok(8), dtok(0));
      row(EOT, EOT, EOT);
      exp_q = '{dtok(50), EOT};
      run_xfer("after_rst", 64'd1, 2'd0, base);
      check_outs("after_rst", base);
      check_val("after_rst_err", 64'(err), 64'd0);

      check_val("ready_with_done", 64'(ready_bad), 64'd0);
      check_val("read_when_empty", 64'(bad_read), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/stream_vadd_multi.md
# stream_vadd_multi

Parametrised, synthesizable element-wise stream combiner: `NUM_IN` HLS-style input streams (`dout`/`empty_n`/`read`, end-of-transfer flag in MSB) are reduced lane-wise into one output stream (`din`/`full_n`/`write`) under `ap_ctrl_hs` control. Successor to the fixed two-input float adder task. Adds integer width/lane-count generics, a runtime op select, close-token checking with a sticky error flag, and one-token output buffering for full throughput.

## Interface
- `NUM_IN`, 2: number of input lanes, ≥2.
- `DATA_WIDTH`, 32: payload bits per token. Token width is `DATA_WIDTH+1`; bit `DATA_WIDTH` is eot.
- `ap_clk` in 1: single clock, all logic rising-edge.
- `ap_rst` in 1: asynchronous, active-high reset.
- `ap_start` in 1: start request, held until `ap_ready`.
- `ap_done` out 1: one-cycle pulse, transfer complete.
- `ap_idle` out 1: high in IDLE.
- `ap_ready` out 1: one-cycle pulse, coincident with `ap_done`.
- `n` in 64: element count, sampled at start.
- `op` in 2: 0 add, 1 sub, 2 unsigned max, 3 reserved (acts as add). Sampled at start.
- `in_dout` in `NUM_IN*(DATA_WIDTH+1)`: lane i occupies slice i.
- `in_empty_n` in `NUM_IN`: lane has a head token.
- `in_read` out `NUM_IN`: pop lane head this cycle.
- `out_din` out `DATA_WIDTH+1`: output token.
- `out_full_n` in 1: sink can accept.
- `out_write` out 1: push output token.
- `err` out 1: sticky protocol error, cleared at start acceptance.

## Operation
- States: IDLE, RUN, DRAIN, EMIT_EOT, DONE.
- IDLE: `ap_idle`=1. On `ap_start`, latch `n` and `op`, clear `count`, `seen`, `err`. Go to RUN, or to DRAIN if `n`=0.
- RUN: fires when all `in_empty_n` are set and `slot_free`. On fire, all `in_read` assert together.
  - All heads data: compute result, load output register, increment `count`. If `count+1`==`n`, go to DRAIN.
  - Any head has eot: set `err`. Data heads are dropped. Set `seen[i]` for eot lanes. Go to DRAIN.
- DRAIN: per lane independently, `in_read[i]` = `in_empty_n[i] & ~seen[i]`.
  - Eot token read: set `seen[i]`.
  - Data token read: set `err` and drop the token.
  - When `seen` is all ones, go to EMIT_EOT.
- EMIT_EOT: when `slot_free`, load `{1'b1, 0}` and go to DONE.
- DONE: wait until the output register is empty (close token accepted). Then pulse `ap_done` and `ap_ready`, and return to IDLE.
- Arithmetic, modulo 2^`DATA_WIDTH`:
  - add: sum of all lanes.
  - sub: lane0 minus the sum of the other lanes.
  - max: unsigned maximum.
- Output eot bit is 0 for data tokens.
- Output register (single entry):
  - `out_write` = `valid & out_full_n`.
  - `slot_free` = `~valid | out_full_n`.
  - Simultaneous drain and load is allowed.

## Timing
- Reset values: `ap_idle`=1; `ap_done`, `ap_ready`, `out_write`, `err`, `in_read` all 0; `out_din`=0; state IDLE; `valid`=0.
- Reset mid-operation abandons the transfer immediately. No close token is emitted and no inputs are read after reset.
- Latency: input fire at cycle k gives earliest `out_write` at cycle k+1.
- Throughput is 1 token/cycle with `out_full_n` held high and inputs always non-empty.
- `in_read` is combinational from `in_empty_n` and `out_full_n`. Never assert it without the matching `empty_n`.
- `out_din` stays stable while `valid` and not accepted.
- `ap_done` occurs no earlier than the cycle after the close token's `out_write`.
- `n` up to 2^64−1; `count` is 64 bits with no wrap.

## Structure
- Package `stream_vadd_pkg` holds:
  - `op_e` (ADD, SUB, MAX, RSVD).
  - `state_e`.
  - Function `mk_token(eot, data)`.
  - Localparam `TOKEN_W` = `DATA_WIDTH+1` is derived in-module.
- Sub-module `stream_out_reg` implements the one-entry output buffer: `load`, `data`, `slot_free`, `din`, `full_n`, `write`.

## Test plan
- `NUM_IN`=2, W=32, add, `n`=5; a=0..4, b=1..5, each followed by eot -> out 1,3,5,7,9, then eot token; `err`=0; single `ap_done`.
- `NUM_IN`=3, sub, `n`=2; lanes {10,3,2}, {0,1,0} -> out 5, 0xFFFFFFFF, eot.
- Max, `n`=3, `out_full_n` toggling every other cycle -> out values correct, none dropped or duplicated, `out_din` stable while stalled.
- `n`=3 but lane1 sends eot after 2 data -> 2 outputs, `err`=1, lane0 drained through its eot, close token emitted, `ap_done`.
- `n`=0 with immediate eot on all lanes -> only a close token is output; `ap_done`; `err`=0.
- Reset asserted after 2 of 5 outputs -> outputs return to reset values next edge; new start with `n`=1 completes correctly and clears `err`.
